// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: MEM-stage CPU port vs. host/debug port.
// CPU has default priority; a starvation counter and host_lock give the host progress.
module dmem_arbiter #(
   parameter int AW       = 20,
   parameter int DW       = 64,
   parameter int MAX_WAIT = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic          cpu_stall,
   output logic          cpu_rvalid,
   output logic [DW-1:0] cpu_rdata,
   input  logic          host_req,
   input  logic          host_we,
   input  logic [AW-1:0] host_addr,
   input  logic [DW-1:0] host_wdata,
   input  logic          host_lock,
   output logic          host_gnt,
   output logic          host_rvalid,
   output logic [DW-1:0] host_rdata,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   localparam logic CPU_PRI  = 1'b0;
   localparam logic HOST_PRI = 1'b1;

   localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

   logic       state_q;
   logic       state_d;
   logic [7:0] wait_cnt;
   logic [7:0] wait_d;
   logic       rd_pend_q;
   logic       rd_owner_q;
   logic       cpu_grant;
   logic       host_grant;
   logic       rd_grant;

   // Grants are gated by rst_n so nothing reaches memory during reset.
   always_comb begin
      cpu_grant  = 1'b0;
      host_grant = 1'b0;
      if (!rst_n) begin
         cpu_grant  = 1'b0;
         host_grant = 1'b0;
      end else if (host_lock) begin
         host_grant = host_req;
      end else if (state_q == HOST_PRI) begin
         host_grant = host_req;
         cpu_grant  = cpu_req & ~host_req;
      end else begin
         cpu_grant  = cpu_req;
         host_grant = host_req & ~cpu_req;
      end
   end

   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (host_grant) begin
         mem_en    = 1'b1;
         mem_we    = host_we;
         mem_addr  = host_addr;
         mem_wdata = host_wdata;
      end else if (cpu_grant) begin
         mem_en    = 1'b1;
         mem_we    = cpu_we;
         mem_addr  = cpu_addr;
         mem_wdata = cpu_wdata;
      end
   end

   always_comb begin
      state_d = state_q;
      wait_d  = wait_cnt;
      if (host_lock) begin
         state_d = CPU_PRI;
         wait_d  = '0;
      end else begin
         if (host_grant || !host_req) begin
            wait_d = '0;
         end else if (wait_cnt < WAIT_LAST) begin
            wait_d = wait_cnt + 8'd1;
         end
         // Host has waited its full budget: flip priority for its next try.
         if (state_q == CPU_PRI) begin
            if (host_req && !host_grant && wait_cnt == WAIT_LAST) begin
               state_d = HOST_PRI;
            end
         end else begin
            if (host_grant || !host_req) begin
               state_d = CPU_PRI;
            end
         end
      end
   end

   assign rd_grant = (host_grant & ~host_we) | (cpu_grant & ~cpu_we);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= CPU_PRI;
         wait_cnt   <= '0;
         rd_pend_q  <= 1'b0;
         rd_owner_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt   <= wait_d;
         rd_pend_q  <= rd_grant;
         rd_owner_q <= host_grant;
      end
   end

   assign cpu_stall   = cpu_req & ~cpu_grant;
   assign host_gnt    = host_grant;
   assign cpu_rvalid  = rd_pend_q & ~rd_owner_q;
   assign host_rvalid = rd_pend_q & rd_owner_q;
   assign cpu_rdata   = mem_rdata;
   assign host_rdata  = mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: sync-read memory stub plus a wait-count
// reference model of grants, read returns and memory contents.
module tb_dmem_arbiter;

   localparam int AW = 20;
   localparam int DW = 64;
   localparam int MW = 8;

   logic          tb_clk;
   logic          rst_n;
   logic          cpu_req;
   logic          cpu_we;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_wdata;
   logic          cpu_stall;
   logic          cpu_rvalid;
   logic [DW-1:0] cpu_rdata;
   logic          host_req;
   logic          host_we;
   logic [AW-1:0] host_addr;
   logic [DW-1:0] host_wdata;
   logic          host_lock;
   logic          host_gnt;
   logic          host_rvalid;
   logic [DW-1:0] host_rdata;
   logic          mem_en;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;

   logic          pl_en;
   logic [7:0]    pl_addr;
   logic [DW-1:0] pl_data;
   logic [DW-1:0] mem [0:255];

   int n_chk;
   int n_fail;

   // reference model state
   logic [DW-1:0] ref_mem [0:255];
   int            waited;
   logic          pend_v;
   logic          pend_host;
   logic [DW-1:0] pend_data;
   logic          e_hg;
   logic          e_cg;
   logic          e_en;
   logic          e_we;
   logic [AW-1:0] e_addr;
   logic [DW-1:0] e_wdata;

   dmem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MW)) dut (
      .clk(tb_clk),
      .rst_n(rst_n),
      .cpu_req(cpu_req),
      .cpu_we(cpu_we),
      .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata),
      .cpu_stall(cpu_stall),
      .cpu_rvalid(cpu_rvalid),
      .cpu_rdata(cpu_rdata),
      .host_req(host_req),
      .host_we(host_we),
      .host_addr(host_addr),
      .host_wdata(host_wdata),
      .host_lock(host_lock),
      .host_gnt(host_gnt),
      .host_rvalid(host_rvalid),
      .host_rdata(host_rdata),
      .mem_en(mem_en),
      .mem_we(mem_we),
      .mem_addr(mem_addr),
      .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   initial tb_clk = 1'b0;
   always #5 tb_clk = ~tb_clk;

   always @(posedge tb_clk) begin
      if (pl_en) begin
         mem[pl_addr] <= pl_data;
      end else if (mem_en) begin
         if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
         else mem_rdata <= mem[mem_addr[7:0]];
      end
   end

   // Host is granted once it has waited MW contended cycles, when the
   // CPU is idle, or under lock; the CPU gets whatever is left.
   task model_eval();
      e_hg = host_req && (host_lock || !cpu_req || waited >= MW);
      e_cg = cpu_req && !host_lock && !e_hg;
      e_en = e_hg || e_cg;
      e_we = e_hg ? host_we : (e_cg ? cpu_we : 1'b0);
      e_addr = e_hg ? host_addr : (e_cg ? cpu_addr : '0);
      e_wdata = e_hg ? host_wdata : (e_cg ? cpu_wdata : '0);
   endtask

   task model_commit();
      if (e_hg || host_lock || !host_req) waited = 0;
      else if (waited < MW) waited++;
      pend_v = e_en && !e_we;
      pend_host = e_hg;
      pend_data = ref_mem[e_addr[7:0]];
      if (e_en && e_we) ref_mem[e_addr[7:0]] = e_wdata;
   endtask

   task model_reset();
      waited = 0;
      pend_v = 1'b0;
      pend_host = 1'b0;
   endtask

   task idle_inputs();
      cpu_req = 1'b0;
      cpu_we = 1'b0;
      cpu_addr = '0;
      cpu_wdata = '0;
      host_req = 1'b0;
      host_we = 1'b0;
      host_addr = '0;
      host_wdata = '0;
      host_lock = 1'b0;
   endtask

   task preload();
      pl_en = 1'b1;
      for (int i = 0; i < 256; i++) begin
         pl_addr = 8'(i);
         pl_data = (i == 3) ? 64'h27 : {$urandom, $urandom};
         ref_mem[i] = pl_data;
         @(posedge tb_clk);
         #1;
      end
      pl_en = 1'b0;
   endtask

   task test_reset();
      rst_n = 1'b0;
      cpu_req = 1'b1;
      host_req = 1'b1;
      @(negedge tb_clk);
      n_chk++;
      if (mem_en !== 1'b0 || host_gnt !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_grant mem_en=%b host_gnt=%b need 0/0", mem_en, host_gnt);
      end
      n_chk++;
      if (cpu_stall !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_stall got %b need 1", cpu_stall);
      end
      n_chk++;
      if (cpu_rvalid !== 1'b0 || host_rvalid !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_rvalid cpu=%b host=%b need 0/0", cpu_rvalid, host_rvalid);
      end
      @(posedge tb_clk);
      #1;
      rst_n = 1'b1;
      host_req = 1'b0;
      cpu_we = 1'b0;
      cpu_addr = 20'd20;
      @(posedge tb_clk);
      #1;
      rst_n = 1'b0;
      cpu_req = 1'b0;
      #1;
      n_chk++;
      if (cpu_rvalid !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_midread cpu_rvalid got %b need 0", cpu_rvalid);
      end
      @(posedge tb_clk);
      #1;
      rst_n = 1'b1;
      @(negedge tb_clk);
      n_chk++;
      if (cpu_rvalid !== 1'b0 || host_rvalid !== 1'b0 || mem_en !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_after rv=%b/%b en=%b need 0", cpu_rvalid, host_rvalid, mem_en);
      end
      model_reset();
      @(posedge tb_clk);
      #1;
   endtask

   task test_cpu_only();
      idle_inputs();
      cpu_req = 1'b1;
      cpu_addr = 20'd3;
      @(negedge tb_clk);
      model_eval();
      n_chk++;
      if (cpu_stall !== 1'b0 || mem_en !== 1'b1 || mem_addr !== 20'd3) begin
         n_fail++;
         $display("FAIL cpu_only stall=%b en=%b addr=%0d need 0/1/3", cpu_stall, mem_en, mem_addr);
      end
      @(posedge tb_clk);
      model_commit();
      #1;
      cpu_req = 1'b0;
      @(negedge tb_clk);
      model_eval();
      n_chk++;
      if (cpu_rvalid !== 1'b1 || host_rvalid !== 1'b0 || cpu_rdata !== 64'h27) begin
         n_fail++;
         $display("FAIL cpu_only_rd rv=%b hrv=%b data=%h need 1/0/27", cpu_rvalid, host_rvalid, cpu_rdata);
      end
      @(posedge tb_clk);
      model_commit();
      #1;
   endtask

   task test_contention();
      idle_inputs();
      for (int i = 0; i < 10; i++) begin
         cpu_req = 1'b1;
         cpu_addr = 20'd9;
         host_req = 1'b1;
         host_addr = 20'd7;
         @(negedge tb_clk);
         model_eval();
         n_chk++;
         if (host_gnt !== (i == 8) || cpu_stall !== (i == 8)) begin
            n_fail++;
            $display("FAIL contention cyc %0d gnt=%b stall=%b need %b", i, host_gnt, cpu_stall, i == 8);
         end
         n_chk++;
         if (cpu_rvalid !== (i > 0 && i != 9) || host_rvalid !== (i == 9)) begin
            n_fail++;
            $display("FAIL contention_rv cyc %0d cpu=%b host=%b", i, cpu_rvalid, host_rvalid);
         end
         if (i > 0) begin
            n_chk++;
            if (cpu_rdata !== pend_data) begin
               n_fail++;
               $display("FAIL contention_data cyc %0d got %h need %h", i, cpu_rdata, pend_data);
            end
         end
         @(posedge tb_clk);
         model_commit();
         #1;
      end
      idle_inputs();
      @(posedge tb_clk);
      model_eval();
      model_commit();
      #1;
   endtask

   task test_lock();
      logic [DW-1:0] wd [0:99];
      int gnts;
      gnts = 0;
      idle_inputs();
      host_lock = 1'b1;
      cpu_req = 1'b1;
      cpu_we = 1'b1;
      cpu_addr = 20'd50;
      for (int i = 0; i < 100; i++) begin
         host_req = 1'b1;
         host_we = 1'b1;
         host_addr = 20'(i + 3);
         wd[i] = {$urandom, $urandom};
         host_wdata = wd[i];
         @(negedge tb_clk);
         model_eval();
         if (host_gnt === 1'b1) gnts++;
         n_chk++;
         if (cpu_stall !== 1'b1) begin
            n_fail++;
            $display("FAIL lock_stall cyc %0d got %b need 1", i, cpu_stall);
         end
         @(posedge tb_clk);
         model_commit();
         #1;
      end
      n_chk++;
      if (gnts != 100) begin
         n_fail++;
         $display("FAIL lock_gnts got %0d need 100", gnts);
      end
      for (int i = 0; i <= 100; i++) begin
         host_req = (i < 100);
         host_we = 1'b0;
         host_addr = 20'(i + 3);
         @(negedge tb_clk);
         model_eval();
         if (i > 0) begin
            n_chk++;
            if (host_rvalid !== 1'b1 || host_rdata !== wd[i-1] || cpu_rvalid !== 1'b0) begin
               n_fail++;
               $display("FAIL lock_readback %0d rv=%b got %h need %h", i - 1, host_rvalid, host_rdata, wd[i-1]);
            end
         end
         @(posedge tb_clk);
         model_commit();
         #1;
      end
      idle_inputs();
      @(posedge tb_clk);
      model_eval();
      model_commit();
      #1;
   endtask

   task test_interleave();
      idle_inputs();
      for (int c = 0; c < 3; c++) begin
         cpu_req = (c == 0);
         cpu_addr = 20'd4;
         host_req = (c == 1);
         host_addr = 20'd5;
         @(negedge tb_clk);
         model_eval();
         if (c == 1) begin
            n_chk++;
            if (cpu_rvalid !== 1'b1 || host_rvalid !== 1'b0 || cpu_rdata !== ref_mem[4]) begin
               n_fail++;
               $display("FAIL ilv_cpu rv=%b/%b data=%h need %h", cpu_rvalid, host_rvalid, cpu_rdata, ref_mem[4]);
            end
         end
         if (c == 2) begin
            n_chk++;
            if (host_rvalid !== 1'b1 || cpu_rvalid !== 1'b0 || host_rdata !== ref_mem[5]) begin
               n_fail++;
               $display("FAIL ilv_host rv=%b/%b data=%h need %h", host_rvalid, cpu_rvalid, host_rdata, ref_mem[5]);
            end
         end
         @(posedge tb_clk);
         model_commit();
         #1;
      end
   endtask

   task test_same_cycle();
      logic [DW-1:0] v;
      logic [DW-1:0] old;
      v = {$urandom, $urandom};
      old = ref_mem[10];
      idle_inputs();
      for (int c = 0; c < 4; c++) begin
         cpu_req = (c == 0 || c == 2);
         cpu_we = 1'b0;
         cpu_addr = 20'd10;
         host_req = (c < 2);
         host_we = 1'b1;
         host_addr = 20'd10;
         host_wdata = v;
         @(negedge tb_clk);
         model_eval();
         if (c == 0) begin
            n_chk++;
            if (host_gnt !== 1'b0 || cpu_stall !== 1'b0 || mem_we !== 1'b0) begin
               n_fail++;
               $display("FAIL same_c0 gnt=%b stall=%b we=%b need 0/0/0", host_gnt, cpu_stall, mem_we);
            end
         end
         if (c == 1) begin
            n_chk++;
            if (host_gnt !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== v) begin
               n_fail++;
               $display("FAIL same_c1 gnt=%b we=%b wd=%h need 1/1/%h", host_gnt, mem_we, mem_wdata, v);
            end
            n_chk++;
            if (cpu_rvalid !== 1'b1 || cpu_rdata !== old) begin
               n_fail++;
               $display("FAIL same_old rv=%b got %h need %h", cpu_rvalid, cpu_rdata, old);
            end
         end
         if (c == 3) begin
            n_chk++;
            if (cpu_rvalid !== 1'b1 || cpu_rdata !== v) begin
               n_fail++;
               $display("FAIL same_new rv=%b got %h need %h", cpu_rvalid, cpu_rdata, v);
            end
         end
         @(posedge tb_clk);
         model_commit();
         #1;
      end
      idle_inputs();
   endtask

   task test_random();
      idle_inputs();
      for (int i = 0; i < 600; i++) begin
         cpu_req = $urandom_range(0, 3) != 0;
         cpu_we = $urandom_range(0, 2) == 0;
         cpu_addr = 20'($urandom_range(0, 255));
         cpu_wdata = {$urandom, $urandom};
         host_lock = $urandom_range(0, 9) == 0;
         if (!host_req) begin
            host_req = $urandom_range(0, 1) == 1;
            host_we = $urandom_range(0, 1) == 1;
            host_addr = 20'($urandom_range(0, 255));
            host_wdata = {$urandom, $urandom};
         end
         @(negedge tb_clk);
         model_eval();
         n_chk++;
         if (host_gnt !== e_hg || cpu_stall !== (cpu_req && !e_cg)) begin
            n_fail++;
            $display("FAIL rnd_grant cyc %0d gnt=%b stall=%b need %b/%b", i, host_gnt, cpu_stall, e_hg, cpu_req && !e_cg);
         end
         n_chk++;
         if (mem_en !== e_en || mem_we !== e_we || mem_addr !== e_addr) begin
            n_fail++;
            $display("FAIL rnd_mem cyc %0d en/we/addr=%b/%b/%0d need %b/%b/%0d", i, mem_en, mem_we, mem_addr, e_en, e_we, e_addr);
         end
         if (e_en && e_we) begin
            n_chk++;
            if (mem_wdata !== e_wdata) begin
               n_fail++;
               $display("FAIL rnd_wdata cyc %0d got %h need %h", i, mem_wdata, e_wdata);
            end
         end
         n_chk++;
         if (cpu_rvalid !== (pend_v && !pend_host) || host_rvalid !== (pend_v && pend_host)) begin
            n_fail++;
            $display("FAIL rnd_rvalid cyc %0d cpu=%b host=%b need %b/%b", i, cpu_rvalid, host_rvalid, pend_v && !pend_host, pend_v && pend_host);
         end
         if (pend_v) begin
            n_chk++;
            if ((pend_host ? host_rdata : cpu_rdata) !== pend_data) begin
               n_fail++;
               $display("FAIL rnd_rdata cyc %0d got %h need %h", i, pend_host ? host_rdata : cpu_rdata, pend_data);
            end
         end
         @(posedge tb_clk);
         model_commit();
         #1;
         if (e_hg) host_req = 1'b0;
      end
      idle_inputs();
   endtask

   initial begin
      n_chk = 0;
      n_fail = 0;
      mem_rdata = '0;
      pl_en = 1'b0;
      pl_addr = '0;
      pl_data = '0;
      rst_n = 1'b0;
      idle_inputs();
      model_reset();
      preload();
      test_reset();
      test_cpu_only();
      test_contention();
      test_lock();
      test_interleave();
      test_same_cycle();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
